// File: rtl/voice_change_frame_ctrl_if.sv
// Handshake/bus bundle for voice_change_frame_ctrl.
//   master : the frame controller (drives interpolator control, output handshake, status)
//   slave  : the surrounding system (config source, capture buffer, interpolator, reader)
// Signal groups: config (p_cfg/cfg_valid/cfg_err), capture (frame_rdy/frame_done),
// interpolator (interp_*), output handshake (out_valid/out_len/out_ack), status (busy/err_timeout).
interface voice_change_frame_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int P_W    = 10
);
  logic [P_W-1:0]    p_cfg;
  logic              cfg_valid;
  logic              cfg_err;
  logic              frame_rdy;
  logic              frame_done;
  logic [P_W-1:0]    interp_p;
  logic [ADDR_W-1:0] interp_wr_addr_max;
  logic              interp_wr_en;
  logic              interp_flag_end;
  logic              out_valid;
  logic [ADDR_W:0]   out_len;
  logic              out_ack;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  p_cfg, cfg_valid, frame_rdy, interp_flag_end, out_ack,
    output cfg_err, frame_done, interp_p, interp_wr_addr_max, interp_wr_en,
           out_valid, out_len, busy, err_timeout
  );

  modport slave (
    output p_cfg, cfg_valid, frame_rdy, interp_flag_end, out_ack,
    input  cfg_err, frame_done, interp_p, interp_wr_addr_max, interp_wr_en,
           out_valid, out_len, busy, err_timeout
  );
endinterface

// File: rtl/voice_change_frame_ctrl.sv
// Frame sequencer for the linear-interpolation pitch/speed datapath.
// Waits for a full capture frame, latches ratio p (Q3.7), computes the last output
// index N = floor(((FRAME_LEN-2)<<FRAC_BITS)/p) with a serial restoring divider,
// opens the interpolator write window for N+1 cycles, waits for its end flag
// (with timeout) and hands the frame to the reader via out_valid/out_ack.
// Ports: clk, rst (async active-high), bus (master modport of voice_change_frame_ctrl_if).
//
// state    | meaning
// IDLE     | waiting for frame_rdy
// CALC     | serial divide, one quotient bit per cycle
// RUN      | interpolator write window open
// WAIT_END | waiting for interpolator end flag, timeout running
// DONE     | output frame offered to reader until out_ack
module voice_change_frame_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int P_W       = 10,
  parameter int FRAC_BITS = 7,
  parameter int TIMEOUT   = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  voice_change_frame_ctrl_if.master    bus
);

  localparam int DIV_W = $clog2(((FRAME_LEN - 2) << FRAC_BITS) + 1);
  localparam int DC_W  = $clog2(DIV_W);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0]  DIVIDEND = DIV_W'((FRAME_LEN - 2) << FRAC_BITS);
  localparam logic [P_W-1:0]    P_ONE    = P_W'(1 << FRAC_BITS);
  localparam logic [P_W-1:0]    P_ZERO   = '0;
  localparam logic [ADDR_W-1:0] N_RST    = ADDR_W'(FRAME_LEN - 2);
  localparam logic [ADDR_W-1:0] N_MAX    = '1;
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [DC_W-1:0]   DC_LOAD  = DC_W'(DIV_W - 1);
  localparam logic [DC_W-1:0]   DC_ONE   = DC_W'(1);
  localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    RUN      = 3'd2,
    WAIT_END = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [P_W-1:0]    shadow_p_q, shadow_p_d;
  logic [P_W-1:0]    interp_p_q, interp_p_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W:0]   out_len_q, out_len_d;
  logic [DIV_W-1:0]  quo_q, quo_d;
  logic [P_W-1:0]    rem_q, rem_d;
  logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
  logic [ADDR_W:0]   run_cnt_q, run_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              frame_done_q, frame_done_d;
  logic              cfg_err_q, cfg_err_d;

  // one restoring-divide step; remainder stays below p so it fits in P_W bits
  logic [P_W:0]      rem_sh;
  logic [P_W:0]      rem_diff;
  logic [P_W-1:0]    rem_step;
  logic [DIV_W-1:0]  quo_step;
  logic [ADDR_W-1:0] n_clamp;
  logic [P_W-1:0]    p_start;

  always_comb begin
    rem_sh   = {rem_q, quo_q[DIV_W-1]};
    rem_diff = rem_sh - {1'b0, interp_p_q};
    if (rem_sh >= {1'b0, interp_p_q}) begin
      rem_step = rem_diff[P_W-1:0];
      quo_step = {quo_q[DIV_W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[P_W-1:0];
      quo_step = {quo_q[DIV_W-2:0], 1'b0};
    end
    n_clamp = (|quo_step[DIV_W-1:ADDR_W]) ? N_MAX : quo_step[ADDR_W-1:0];
    // a valid write arriving with the frame start wins over the shadow
    p_start = (bus.cfg_valid && (bus.p_cfg != P_ZERO)) ? bus.p_cfg : shadow_p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_p_q    <= P_ONE;
      interp_p_q    <= P_ONE;
      n_q           <= N_RST;
      out_len_q     <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      div_cnt_q     <= '0;
      run_cnt_q     <= '0;
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
      frame_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_p_q    <= shadow_p_d;
      interp_p_q    <= interp_p_d;
      n_q           <= n_d;
      out_len_q     <= out_len_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      div_cnt_q     <= div_cnt_d;
      run_cnt_q     <= run_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
      frame_done_q  <= frame_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shadow_p_d    = shadow_p_q;
    interp_p_d    = interp_p_q;
    n_d           = n_q;
    out_len_d     = out_len_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    div_cnt_d     = div_cnt_q;
    run_cnt_d     = run_cnt_q;
    to_cnt_d      = to_cnt_q;
    err_timeout_d = err_timeout_q;
    frame_done_d  = 1'b0;
    cfg_err_d     = 1'b0;

    if (bus.cfg_valid) begin
      if (bus.p_cfg == P_ZERO) cfg_err_d  = 1'b1;
      else                     shadow_p_d = bus.p_cfg;
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_rdy) begin
          interp_p_d    = p_start;
          err_timeout_d = 1'b0;
          quo_d         = DIVIDEND;
          rem_d         = '0;
          div_cnt_d     = DC_LOAD;
          state_d       = CALC;
        end
      end
      CALC: begin
        quo_d     = quo_step;
        rem_d     = rem_step;
        div_cnt_d = div_cnt_q - DC_ONE;
        if (div_cnt_q == '0) begin
          n_d       = n_clamp;
          out_len_d = {1'b0, n_clamp} + LEN_ONE;
          run_cnt_d = {1'b0, n_clamp};
          state_d   = RUN;
        end
      end
      RUN: begin
        if (run_cnt_q == '0) begin
          to_cnt_d = TO_LOAD;
          state_d  = WAIT_END;
        end else begin
          run_cnt_d = run_cnt_q - LEN_ONE;
        end
      end
      WAIT_END: begin
        if (bus.interp_flag_end) begin
          frame_done_d = 1'b1;
          state_d      = DONE;
        end else if (to_cnt_q == '0) begin
          err_timeout_d = 1'b1;
          frame_done_d  = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_ONE;
        end
      end
      DONE: begin
        if (bus.out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // write window and handshake decode straight from state so reset drops them at once
  always_comb begin
    bus.interp_wr_en       = (state_q == RUN);
    bus.out_valid          = (state_q == DONE);
    bus.busy               = (state_q != IDLE);
    bus.interp_p           = interp_p_q;
    bus.interp_wr_addr_max = n_q;
    bus.out_len            = out_len_q;
    bus.err_timeout        = err_timeout_q;
    bus.frame_done         = frame_done_q;
    bus.cfg_err            = cfg_err_q;
  end

endmodule

// File: tb/tb_voice_change_frame_ctrl.sv
module tb_voice_change_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  voice_change_frame_ctrl_if bus();

  voice_change_frame_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_p(input int p);
    bus.p_cfg     = 10'(p);
    bus.cfg_valid = 1'b1;
    tick(1);
    bus.cfg_valid = 1'b0;
  endtask

  // starts a frame and measures: lat = index of first edge (after the frame_rdy
  // sampling edge) that sees interp_wr_en high; wr = length of the window
  task automatic do_frame(input logic hold_rdy, output int lat, output int wr);
    bus.frame_rdy = 1'b1;
    tick(1);
    bus.cfg_valid = 1'b0;
    if (!hold_rdy) bus.frame_rdy = 1'b0;
    lat = 1;
    while (!bus.interp_wr_en && lat < 100) begin
      tick(1);
      lat++;
    end
    wr = 0;
    while (bus.interp_wr_en && wr < 2000) begin
      wr++;
      tick(1);
    end
  endtask

  task automatic finish_frame();
    bus.interp_flag_end = 1'b1;
    tick(1);
    bus.interp_flag_end = 1'b0;
    bus.out_ack = 1'b1;
    tick(1);
    bus.out_ack = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    n_cmp++; if (int'(bus.interp_p) !== 128) begin n_bad++; $display("FAIL reset_interp_p got %0d want 128", bus.interp_p); end
    n_cmp++; if (int'(bus.interp_wr_addr_max) !== 1022) begin n_bad++; $display("FAIL reset_n got %0d want 1022", bus.interp_wr_addr_max); end
    n_cmp++; if ({bus.busy, bus.out_valid, bus.interp_wr_en, bus.frame_done, bus.cfg_err, bus.err_timeout} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 000000", {bus.busy, bus.out_valid, bus.interp_wr_en, bus.frame_done, bus.cfg_err, bus.err_timeout});
    end
    n_cmp++; if (int'(bus.out_len) !== 0) begin n_bad++; $display("FAIL reset_out_len got %0d want 0", bus.out_len); end
  endtask

  task automatic test_p128();
    int lat, wr;
    do_frame(1'b0, lat, wr);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL p128_latency got %0d want 18", lat); end
    n_cmp++; if (wr !== 1023) begin n_bad++; $display("FAIL p128_wr_cycles got %0d want 1023", wr); end
    n_cmp++; if (int'(bus.interp_wr_addr_max) !== 1022) begin n_bad++; $display("FAIL p128_n got %0d want 1022", bus.interp_wr_addr_max); end
    n_cmp++; if (int'(bus.out_len) !== 1023) begin n_bad++; $display("FAIL p128_out_len got %0d want 1023", bus.out_len); end
    tick(3);
    n_cmp++; if ({bus.busy, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL p128_wait got busy/valid %b want 10", {bus.busy, bus.out_valid}); end
    bus.interp_flag_end = 1'b1;
    tick(1);
    bus.interp_flag_end = 1'b0;
    n_cmp++; if ({bus.frame_done, bus.out_valid} !== 2'b11) begin n_bad++; $display("FAIL p128_done got done/valid %b want 11", {bus.frame_done, bus.out_valid}); end
    tick(2);
    n_cmp++; if ({bus.frame_done, bus.out_valid} !== 2'b01) begin n_bad++; $display("FAIL p128_hold got done/valid %b want 01", {bus.frame_done, bus.out_valid}); end
    bus.out_ack = 1'b1;
    tick(1);
    bus.out_ack = 1'b0;
    n_cmp++; if ({bus.busy, bus.out_valid} !== 2'b00) begin n_bad++; $display("FAIL p128_ack got busy/valid %b want 00", {bus.busy, bus.out_valid}); end
  endtask

  task automatic test_divider();
    int p_tab[3] = '{256, 200, 64};
    int n_tab[3] = '{511, 654, 1023};
    int lat, wr;
    for (int k = 0; k < 3; k++) begin
      set_p(p_tab[k]);
      do_frame(1'b0, lat, wr);
      n_cmp++; if (int'(bus.interp_wr_addr_max) !== n_tab[k]) begin n_bad++; $display("FAIL div_n p=%0d got %0d want %0d", p_tab[k], bus.interp_wr_addr_max, n_tab[k]); end
      n_cmp++; if (wr !== n_tab[k] + 1) begin n_bad++; $display("FAIL div_wr p=%0d got %0d want %0d", p_tab[k], wr, n_tab[k] + 1); end
      n_cmp++; if (int'(bus.out_len) !== n_tab[k] + 1) begin n_bad++; $display("FAIL div_len p=%0d got %0d want %0d", p_tab[k], bus.out_len, n_tab[k] + 1); end
      n_cmp++; if (int'(bus.interp_p) !== p_tab[k]) begin n_bad++; $display("FAIL div_p got %0d want %0d", bus.interp_p, p_tab[k]); end
      finish_frame();
    end
  endtask

  task automatic test_config();
    int lat, wr, cnt;
    set_p(128);
    bus.p_cfg = 10'd0;
    bus.cfg_valid = 1'b1;
    tick(1);
    bus.cfg_valid = 1'b0;
    n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_pulse got %b want 1", bus.cfg_err); end
    tick(1);
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clear got %b want 0", bus.cfg_err); end
    // mid-run write of 256 must not disturb the current frame (shadow still 128)
    bus.frame_rdy = 1'b1;
    tick(1);
    bus.frame_rdy = 1'b0;
    cnt = 0;
    while (!bus.interp_wr_en && cnt < 100) begin tick(1); cnt++; end
    wr = 0;
    while (bus.interp_wr_en && wr < 2000) begin
      if (wr == 100) begin bus.p_cfg = 10'd256; bus.cfg_valid = 1'b1; end
      if (wr == 101) bus.cfg_valid = 1'b0;
      wr++;
      tick(1);
    end
    n_cmp++; if (wr !== 1023) begin n_bad++; $display("FAIL cfg_midrun_wr got %0d want 1023", wr); end
    n_cmp++; if (int'(bus.interp_p) !== 128) begin n_bad++; $display("FAIL cfg_midrun_p got %0d want 128", bus.interp_p); end
    finish_frame();
    do_frame(1'b0, lat, wr);
    n_cmp++; if (int'(bus.interp_wr_addr_max) !== 511) begin n_bad++; $display("FAIL cfg_next_n got %0d want 511", bus.interp_wr_addr_max); end
    finish_frame();
    // write coinciding with frame start is used immediately
    bus.p_cfg = 10'd200;
    bus.cfg_valid = 1'b1;
    do_frame(1'b0, lat, wr);
    n_cmp++; if (int'(bus.interp_wr_addr_max) !== 654) begin n_bad++; $display("FAIL cfg_bypass_n got %0d want 654", bus.interp_wr_addr_max); end
    finish_frame();
    set_p(128);
  endtask

  task automatic test_timeout();
    int lat, wr;
    do_frame(1'b0, lat, wr);
    tick(4094);
    n_cmp++; if ({bus.err_timeout, bus.frame_done, bus.busy} !== 3'b001) begin n_bad++; $display("FAIL to_early got err/done/busy %b want 001", {bus.err_timeout, bus.frame_done, bus.busy}); end
    tick(1);
    n_cmp++; if ({bus.err_timeout, bus.frame_done, bus.busy, bus.out_valid} !== 4'b1100) begin n_bad++; $display("FAIL to_fire got err/done/busy/valid %b want 1100", {bus.err_timeout, bus.frame_done, bus.busy, bus.out_valid}); end
    tick(1);
    n_cmp++; if ({bus.err_timeout, bus.frame_done, bus.out_valid} !== 3'b100) begin n_bad++; $display("FAIL to_after got err/done/valid %b want 100", {bus.err_timeout, bus.frame_done, bus.out_valid}); end
    bus.frame_rdy = 1'b1;
    tick(1);
    bus.frame_rdy = 1'b0;
    n_cmp++; if ({bus.err_timeout, bus.busy} !== 2'b01) begin n_bad++; $display("FAIL to_clear got err/busy %b want 01", {bus.err_timeout, bus.busy}); end
  endtask

  task automatic test_async_reset();
    int cnt = 0;
    while (!bus.interp_wr_en && cnt < 100) begin tick(1); cnt++; end
    tick(5);
    n_cmp++; if (bus.interp_wr_en !== 1'b1) begin n_bad++; $display("FAIL arst_pre got wr_en %b want 1", bus.interp_wr_en); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.interp_wr_en, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL arst_now got wr_en/busy %b want 00", {bus.interp_wr_en, bus.busy}); end
    #1 rst = 1'b0;
    tick(1);
    bus.out_ack = 1'b1;
    bus.interp_flag_end = 1'b1;
    tick(3);
    n_cmp++; if ({bus.busy, bus.out_valid, bus.frame_done} !== 3'b000) begin n_bad++; $display("FAIL stray_idle got busy/valid/done %b want 000", {bus.busy, bus.out_valid, bus.frame_done}); end
    bus.out_ack = 1'b0;
    bus.interp_flag_end = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    int lat, wr, cnt;
    do_frame(1'b1, lat, wr);
    n_cmp++; if (wr !== 1023) begin n_bad++; $display("FAIL b2b_wr got %0d want 1023", wr); end
    finish_frame();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got busy %b want 0", bus.busy); end
    tick(1);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got busy %b want 1", bus.busy); end
    bus.frame_rdy = 1'b0;
    cnt = 0;
    while (!bus.interp_wr_en && cnt < 100) begin tick(1); cnt++; end
    n_cmp++; if (cnt !== 17) begin n_bad++; $display("FAIL b2b_latency got %0d want 17", cnt); end
    wr = 0;
    while (bus.interp_wr_en && wr < 2000) begin wr++; tick(1); end
    finish_frame();
  endtask

  initial begin
    bus.p_cfg           = '0;
    bus.cfg_valid       = 1'b0;
    bus.frame_rdy       = 1'b0;
    bus.interp_flag_end = 1'b0;
    bus.out_ack         = 1'b0;
    test_reset();
    test_p128();
    test_divider();
    test_config();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
